module_bcdabin: RTL and testbench
=================================

Name: module_bcdabin

Overview:
- Sequential BCD-to-binary converter, the inverse of the binary-to-BCD decoder.
- Takes two BCD digits (tens `dec`, units `uni`) and returns the 8-bit binary value 0..99.
- Uses reverse double-dabble: shift right, then subtract 3 from every BCD nibble >= 8.
- Sits between digit-entry logic (keypad/display editing) and arithmetic blocks that consume binary operands; start/busy/done handshake.

Parameters:
- BIN_W, 8, width of binary result; fixed at 8 for this block (values 0..99 need 7 bits, MSB always 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request conversion; sampled only in IDLE.
- dec  input  4  tens BCD digit, sampled on the accepted start edge.
- uni  input  4  units BCD digit, sampled on the accepted start edge.
- b  output  8  binary result, registered, held until next result.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse: b and err are valid/updated.
- err  output  1  registered; 1 if the last request had a digit > 9.

Behaviour:
- Reset (async, rst=1): state=IDLE, b=0, busy=0, done=0, err=0, shift counter=0, internal shift register=0. Reset mid-conversion aborts the conversion; no done pulse is produced afterwards.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Edge with start=1 and dec<=9 and uni<=9: load bcd_reg={dec,uni}, bin_reg=0, cnt=0, go to SHIFT.
  - Edge with start=1 and either digit >9: b<=0, err<=1, go to DONE. No shifting. This mirrors the 00 returned for out-of-range values.
  - start=0: stay in IDLE.
- SHIFT (busy=1):
  - Each edge: {bcd_reg,bin_reg} shifts right by 1; then each 4-bit nibble of bcd_reg that is >=8 has 3 subtracted; cnt++.
  - After the 8th shift (cnt==7 at the edge): b<=bin_reg result, err<=0, go to DONE.
  - start is ignored while in SHIFT; dec/uni changes have no effect.
- DONE: done=1 for exactly this one cycle, busy=0. Next edge goes to IDLE unconditionally; start asserted in DONE is ignored.
- Latency, valid request accepted at edge E0: busy high from E0 through E8, DONE entered at E8, done high during the cycle after E8, IDLE at E9. Next start accepted at E9 at the earliest.
- Latency, invalid request: DONE entered at E1 with err=1, b=0.
- b and err hold their values between done pulses.
- Arithmetic: result equals dec*10+uni, 0..99; b[7] is always 0 for valid input.

Optional Feature:
- Macro: BCDABIN_FAST_EN.
- Defined:
  - SHIFT state and shift counter are omitted.
  - A valid start in IDLE registers b<=dec*10+uni (dec*8+dec*2+uni) and goes directly to DONE.
  - done pulses in the cycle after the start edge; busy is always 0.
  - Invalid-digit behaviour is unchanged.
- Undefined: the 8-cycle serial reverse double-dabble described above. Port list is identical in both builds.

Test Plan:
- rst pulse, then idle -> b=0, busy=0, done=0, err=0; rst is asynchronous (outputs clear without a clock edge).
- start with dec=4, uni=5 -> busy for 8 cycles, then done one cycle with b=8'd45, err=0. Repeat for 1/0->10, 8/1->81, 0/5->5, 9/9->99, 0/0->0, each with done exactly once.
- start with dec=4'hA, uni=3 -> done in the next cycle, b=0, err=1. Then a valid 2/7 -> b=27, err=0.
- start held high continuously, with dec/uni changed to 6/6 during SHIFT after a 3/1 request -> b=31 at done; next conversion starts only at the edge after DONE.
- rst asserted at the 4th SHIFT cycle of 7/2 -> outputs cleared immediately, no done pulse. A following 1/2 request -> b=12.
- Build with BCDABIN_FAST_EN, start 8/1 -> done in the cycle after start, b=81, busy never high; invalid-digit case as above.

Source files
------------

// File: rtl/module_bcdabin.sv
// BCD-to-binary converter: two BCD digits (tens, units) in, 8-bit binary 0..99 out.
// Default build runs an 8-cycle reverse double-dabble; define BCDABIN_FAST_EN for single-cycle multiply-add.
module module_bcdabin #(
    parameter int BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       dec,
    input  logic [3:0]       uni,
    output logic [BIN_W-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef BCDABIN_FAST_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t state, state_nxt;
    logic   digits_ok;

    assign digits_ok = (dec <= 4'd9) && (uni <= 4'd9);
    assign done      = (state == DONE);

`ifdef BCDABIN_FAST_EN
    logic [BIN_W-1:0] fast_sum;

    // dec*10 built from shifts: dec*8 + dec*2 + uni
    assign fast_sum = BIN_W'({1'b0, dec, 3'b000}) + BIN_W'({3'b000, dec, 1'b0}) + BIN_W'({4'b0000, uni});
    assign busy     = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            b     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                if (digits_ok) begin
                    b   <= fast_sum;
                    err <= 1'b0;
                end else begin
                    b   <= '0;
                    err <= 1'b1;
                end
            end
        end
    end
`else
    logic [7:0]       bcd_reg, bcd_nxt;
    logic [BIN_W-1:0] bin_reg, bin_nxt;
    logic [2:0]       cnt;
    logic [7+BIN_W:0] shv;

    // Shift right as one long register, then correct any BCD nibble that went >= 8
    always_comb begin
        shv          = {bcd_reg, bin_reg} >> 1;
        bin_nxt      = shv[BIN_W-1:0];
        bcd_nxt      = shv[7+BIN_W:BIN_W];
        if (bcd_nxt[7:4] >= 4'd8) bcd_nxt[7:4] = bcd_nxt[7:4] - 4'd3;
        if (bcd_nxt[3:0] >= 4'd8) bcd_nxt[3:0] = bcd_nxt[3:0] - 4'd3;
    end

    assign busy = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = digits_ok ? SHIFT : DONE;
            SHIFT:   if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            b       <= '0;
            err     <= 1'b0;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (digits_ok) begin
                            bcd_reg <= {dec, uni};
                            bin_reg <= '0;
                            cnt     <= '0;
                        end else begin
                            b   <= '0;
                            err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_nxt;
                    bin_reg <= bin_nxt;
                    cnt     <= cnt + 3'd1;
                    // The eighth shift leaves the full binary value in bin_nxt
                    if (cnt == 3'd7) begin
                        b   <= bin_nxt;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_module_bcdabin.sv
// Directed bench for module_bcdabin; follows BCDABIN_FAST_EN to pick the expected latency.
module tb_module_bcdabin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dec;
    logic [3:0] uni;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BCDABIN_FAST_EN
    localparam int EXP_BUSY = 0;
`else
    localparam int EXP_BUSY = 8;
`endif

    // {dec, uni, expected binary}
    logic [15:0] vecs [7] = '{16'h452D, 16'h100A, 16'h8151, 16'h0505, 16'h9963, 16'h0000, 16'h633F};

    module_bcdabin #(.BIN_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dec   (dec),
        .uni   (uni),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dec = '0; uni = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({b, busy, done, err} !== 11'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: b=%0d busy=%b done=%b err=%b, want all 0", b, busy, done, err);
        end
    endtask

    task automatic test_valid();
        int  nb;
        bit  got;
        for (int i = 0; i < 7; i++) begin
            start = 1'b1; dec = vecs[i][15:12]; uni = vecs[i][11:8];
            @(posedge clk); #1 start = 1'b0;
            nb = 0; got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (done) got = 1;
                else begin
                    if (busy) nb++;
                    @(posedge clk); #1;
                end
            end
            n_checks++;
            if (!got) begin
                n_fail++; $display("[TB] FAIL valid_timeout %0d%0d: no done within 20 cycles", dec, uni);
            end
            n_checks++;
            if (nb != EXP_BUSY) begin
                n_fail++; $display("[TB] FAIL valid_busy %0d%0d: busy cycles %0d, want %0d", dec, uni, nb, EXP_BUSY);
            end
            n_checks++;
            if (b !== vecs[i][7:0] || err !== 1'b0) begin
                n_fail++; $display("[TB] FAIL valid_result %0d%0d: b=%0d err=%b, want b=%0d err=0", dec, uni, b, err, vecs[i][7:0]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || b !== vecs[i][7:0]) begin
                n_fail++; $display("[TB] FAIL valid_after %0d%0d: done=%b b=%0d, want done=0 b=%0d", dec, uni, done, b, vecs[i][7:0]);
            end
        end
    endtask

    task automatic test_invalid();
        int  nb;
        bit  got;
        logic [7:0] pairs [2] = '{8'hA3, 8'h3F};
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; dec = pairs[i][7:4]; uni = pairs[i][3:0];
            @(posedge clk); #1 start = 1'b0;
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || b !== 8'd0 || err !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL invalid_%h: done=%b busy=%b b=%0d err=%b, want done=1 busy=0 b=0 err=1", pairs[i], done, busy, b, err);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || err !== 1'b1) begin
                n_fail++; $display("[TB] FAIL invalid_hold_%h: done=%b err=%b, want done=0 err=1", pairs[i], done, err);
            end
        end
        // A valid request afterwards clears err
        start = 1'b1; dec = 4'd2; uni = 4'd7;
        @(posedge clk); #1 start = 1'b0;
        got = 0; nb = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            else begin
                if (busy) nb++;
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!got || nb != EXP_BUSY || b !== 8'd27 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL after_invalid_27: got=%b busy=%0d b=%0d err=%b, want done busy=%0d b=27 err=0", got, nb, b, err, EXP_BUSY);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_held();
        int  nb;
        bit  got;
        start = 1'b1; dec = 4'd3; uni = 4'd1;
        @(posedge clk); #1;
        dec = 4'd6; uni = 4'd6;
        got = 0; nb = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            else begin
                if (busy) nb++;
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!got || nb != EXP_BUSY || b !== 8'd31) begin
            n_fail++; $display("[TB] FAIL held_31: got=%b busy=%0d b=%0d, want busy=%0d b=31", got, nb, b, EXP_BUSY);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL held_gap: done=%b busy=%b, want both 0 (start ignored in DONE)", done, busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
`ifdef BCDABIN_FAST_EN
        if (done !== 1'b1 || b !== 8'd66) begin
            n_fail++; $display("[TB] FAIL held_restart: done=%b b=%0d, want done=1 b=66", done, b);
        end
`else
        if (busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL held_restart: busy=%b, want 1", busy);
        end
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!got || b !== 8'd66) begin
            n_fail++; $display("[TB] FAIL held_66: got=%b b=%0d, want b=66", got, b);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit saw;
        bit got;
        start = 1'b1; dec = 4'd7; uni = 4'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (EXP_BUSY > 0 ? 3 : 0) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({b, busy, done, err} !== 11'd0) begin
            n_fail++; $display("[TB] FAIL reset_async: b=%0d busy=%b done=%b err=%b, want all 0", b, busy, done, err);
        end
        #1 rst = 1'b0;
        saw = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1;
        end
        n_checks++;
        if (saw) begin
            n_fail++; $display("[TB] FAIL reset_abort: done/busy seen after abort, want none");
        end
        start = 1'b1; dec = 4'd1; uni = 4'd2;
        @(posedge clk); #1 start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!got || b !== 8'd12 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_then_12: got=%b b=%0d err=%b, want b=12 err=0", got, b, err);
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_invalid();
        test_start_held();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
